frac_pulse_gen: RTL

FRAC_PULSE_GEN -- requirements
Module: frac_pulse_gen

---
 rtl/frac_pulse_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/frac_pulse_gen.sv
// rtl/frac_pulse_gen.sv - Programmable divide-by-(C+1) pulse generator with saturating Z event counter
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   X        count-enable pulse stream (one accepted pulse per cycle it is high in RUN)
//   C        threshold offered for load; a pulse every C+1 accepted X pulses
//   c_valid  C is valid this cycle
//   c_ready  block accepts C this cycle (low while stop is requested)
//   stop     request to return to IDLE
//   Y        current count, 0..C_reg
//   Z        registered one-cycle terminal-count pulse
//   busy     high while in RUN
//   z_cnt    saturating count of Z pulses since the last load

module frac_pulse_gen #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          X,
    input  logic [W-1:0]  C,
    input  logic          c_valid,
    output logic          c_ready,
    input  logic          stop,
    output logic [W-1:0]  Y,
    output logic          Z,
    output logic          busy,
    output logic [CW-1:0] z_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [W-1:0]  c_reg_q;
    logic [W-1:0]  y_q;
    logic          z_q;
    logic [CW-1:0] z_cnt_q;

    logic          load;
    logic          at_term;
    logic [CW-1:0] z_cnt_d;

    // stop masks c_ready, so a load can never coincide with a stop request.
    assign c_ready = ~stop;
    assign load    = c_valid & c_ready;
    assign at_term = (y_q == c_reg_q);
    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign z_cnt_d = (z_cnt_q == {CW{1'b1}}) ? z_cnt_q : z_cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_reg_q <= '0;
            y_q     <= '0;
            z_q     <= 1'b0;
            z_cnt_q <= '0;
        end else if (load) begin
            // A load wins over any X in the same cycle, in either state.
            state_q <= RUN;
            c_reg_q <= C;
            y_q     <= '0;
            z_q     <= 1'b0;
            z_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    y_q <= '0;
                    z_q <= 1'b0;
                end
                RUN: begin
                    if (stop) begin
                        // C_reg and z_cnt are kept so software can still read the tally.
                        state_q <= IDLE;
                        y_q     <= '0;
                        z_q     <= 1'b0;
                    end else if (X) begin
                        if (at_term) begin
                            y_q     <= '0;
                            z_q     <= 1'b1;
                            z_cnt_q <= z_cnt_d;
                        end else begin
                            y_q <= y_q + W'(1);
                            z_q <= 1'b0;
                        end
                    end else begin
                        z_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    y_q     <= '0;
                    z_q     <= 1'b0;
                end
            endcase
        end
    end

    assign Y     = y_q;
    assign Z     = z_q;
    assign busy  = (state_q == RUN);
    assign z_cnt = z_cnt_q;

endmodule
